// File: rtl/score_pkg.sv
// Shared types and constants for the score keeper: FSM encoding, BCD digit type,
// seven-segment codes and a single-digit decimal-adjusting adder.
package score_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE = 3'd0;
  localparam state_t ADD0 = 3'd1;
  localparam state_t ADD1 = 3'd2;
  localparam state_t ADD2 = 3'd3;
  localparam state_t CMP  = 3'd4;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  localparam logic [11:0] SCORE_MAX = 12'h999;

  // Returns {carry, digit}; inputs are legal digits so the raw sum never exceeds 18.
  function automatic logic [4:0] bcd_add(input bcd_t a, input bcd_t b);
    logic [4:0] sum;
    logic [4:0] adj;
    sum = {1'b0, a} + {1'b0, b};
    adj = sum - 5'd10;
    if (sum > 5'd9) begin
      return {1'b1, adj[3:0]};
    end
    return sum;
  endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Lock-event handshake from the line-clear controller into the score keeper.
interface score_keeper_if;
  logic       clr_valid;
  logic [2:0] clr_lines;
  logic       clr_ready;

  modport master (output clr_valid, output clr_lines, input clr_ready);
  modport slave  (input clr_valid, input clr_lines, output clr_ready);
endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low {g,f,e,d,c,b,a} segments; illegal digits blank.
module bcd_to_7seg
  import score_pkg::*;
(
  input  bcd_t       digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = SEG_DIGIT[0];
      4'd1: seg = SEG_DIGIT[1];
      4'd2: seg = SEG_DIGIT[2];
      4'd3: seg = SEG_DIGIT[3];
      4'd4: seg = SEG_DIGIT[4];
      4'd5: seg = SEG_DIGIT[5];
      4'd6: seg = SEG_DIGIT[6];
      4'd7: seg = SEG_DIGIT[7];
      4'd8: seg = SEG_DIGIT[8];
      4'd9: seg = SEG_DIGIT[9];
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_keeper.sv
// Accumulates a saturating 3-digit BCD score from lock events (one digit per cycle),
// tracks the best score, and drives six registered seven-segment displays.
module score_keeper
  import score_pkg::*;
#(
  parameter bcd_t PTS_1 = 4'd1,
  parameter bcd_t PTS_2 = 4'd3,
  parameter bcd_t PTS_3 = 4'd5,
  parameter bcd_t PTS_4 = 4'd8
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  score_keeper_if.slave  clr,
  input  logic           new_game,
  output logic           busy,
  output logic [11:0]    score_bcd,
  output logic [11:0]    best_bcd,
  output logic [6:0]     HEX0,
  output logic [6:0]     HEX1,
  output logic [6:0]     HEX2,
  output logic [6:0]     HEX3,
  output logic [6:0]     HEX4,
  output logic [6:0]     HEX5
);

  state_t     state;
  bcd_t       pts;
  bcd_t       pts_sel;
  logic       carry;
  logic [4:0] units_sum;
  logic [4:0] tens_sum;
  logic [4:0] hund_sum;

  always_comb begin
    pts_sel = 4'd0;
    case (clr.clr_lines)
      3'd0:    pts_sel = 4'd0;
      3'd1:    pts_sel = PTS_1;
      3'd2:    pts_sel = PTS_2;
      3'd3:    pts_sel = PTS_3;
      default: pts_sel = PTS_4;
    endcase
  end

  // Ready depends only on registered state, so there is no valid-to-ready path.
  assign clr.clr_ready = (state == IDLE);
  assign busy          = (state != IDLE);

  assign units_sum = bcd_add(score_bcd[3:0], pts);
  assign tens_sum  = bcd_add(score_bcd[7:4], {3'b000, carry});
  assign hund_sum  = bcd_add(score_bcd[11:8], {3'b000, carry});

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pts       <= 4'd0;
      carry     <= 1'b0;
      score_bcd <= 12'h000;
      best_bcd  <= 12'h000;
    end else if (new_game) begin
      state     <= IDLE;
      carry     <= 1'b0;
      score_bcd <= 12'h000;
    end else begin
      case (state)
        IDLE: begin
          if (clr.clr_valid) begin
            pts   <= pts_sel;
            state <= ADD0;
          end
        end
        ADD0: begin
          score_bcd[3:0] <= units_sum[3:0];
          carry          <= units_sum[4];
          state          <= ADD1;
        end
        ADD1: begin
          score_bcd[7:4] <= tens_sum[3:0];
          carry          <= tens_sum[4];
          state          <= ADD2;
        end
        ADD2: begin
          if (hund_sum[4]) begin
            score_bcd <= SCORE_MAX;
          end else begin
            score_bcd[11:8] <= hund_sum[3:0];
          end
          carry <= 1'b0;
          state <= CMP;
        end
        CMP: begin
          if (score_bcd > best_bcd) begin
            best_bcd <= score_bcd;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Digit order: 0..2 score units..hundreds, 3..5 best units..hundreds.
  logic [5:0][3:0] digit;
  logic [5:0][6:0] seg;
  logic [5:0][6:0] hex_q;

  assign digit = {best_bcd, score_bcd};

  for (genvar i = 0; i < 6; i++) begin : g_seg
    bcd_to_7seg u_seg (
      .digit (digit[i]),
      .seg   (seg[i])
    );
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      hex_q <= {6{SEG_DIGIT[0]}};
    end else begin
      hex_q <= seg;
    end
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_score_keeper.sv
// Directed, table-driven bench for score_keeper with hand-computed expectations.
module tb_score_keeper;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        new_game;
  logic        busy;
  logic [11:0] score_bcd;
  logic [11:0] best_bcd;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  score_keeper_if clr_if ();

  score_keeper dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .clr       (clr_if),
    .new_game  (new_game),
    .busy      (busy),
    .score_bcd (score_bcd),
    .best_bcd  (best_bcd),
    .HEX0      (HEX0),
    .HEX1      (HEX1),
    .HEX2      (HEX2),
    .HEX3      (HEX3),
    .HEX4      (HEX4),
    .HEX5      (HEX5)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  localparam logic [6:0] SEGS [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef struct {
    logic [2:0]  lines;
    logic [11:0] score;
    logic [11:0] best;
  } vec_t;

  vec_t tbl [8];
  int checks = 0;
  int errors = 0;
  logic [11:0] exp_s, exp_b;

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Independent reference: decimal value arithmetic, saturating at 999.
  function automatic logic [11:0] model_add(input logic [11:0] s, input logic [2:0] l);
    int v;
    int p;
    logic [3:0] h, t, u;
    v = int'(s[11:8]) * 100 + int'(s[7:4]) * 10 + int'(s[3:0]);
    case (l)
      3'd0: p = 0;
      3'd1: p = 1;
      3'd2: p = 3;
      3'd3: p = 5;
      default: p = 8;
    endcase
    v = v + p;
    if (v > 999) v = 999;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  task automatic check_reset_values(input string nm);
    chk({nm, " score"}, score_bcd, 12'h000);
    chk({nm, " best"}, best_bcd, 12'h000);
    chk({nm, " ready"}, {11'b0, clr_if.clr_ready}, 12'd1);
    chk({nm, " busy"}, {11'b0, busy}, 12'd0);
    chk({nm, " HEX0"}, {5'b0, HEX0}, 12'h040);
    chk({nm, " HEX2"}, {5'b0, HEX2}, 12'h040);
    chk({nm, " HEX3"}, {5'b0, HEX3}, 12'h040);
    chk({nm, " HEX5"}, {5'b0, HEX5}, 12'h040);
  endtask

  // Called just after a falling edge; returns just after the falling edge following T+4.
  task automatic send(input logic [2:0] lines, input bit timed,
                      input logic [11:0] es, input logic [11:0] eb, input string nm);
    int n;
    n = 0;
    clr_if.clr_valid = 1'b1;
    clr_if.clr_lines = lines;
    while (!clr_if.clr_ready && n < 20) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (!clr_if.clr_ready) begin
      checks++;
      errors++;
      $display("FAIL %s accept: clr_ready not seen within 20 cycles", nm);
      clr_if.clr_valid = 1'b0;
      return;
    end
    @(negedge CLOCK_50);
    clr_if.clr_valid = 1'b0;
    clr_if.clr_lines = 3'd0;
    if (timed) chk({nm, " ready@T"}, {11'b0, clr_if.clr_ready}, 12'd0);
    repeat (3) @(negedge CLOCK_50);
    if (timed) chk({nm, " ready@T+3"}, {11'b0, clr_if.clr_ready}, 12'd0);
    chk({nm, " score@T+3"}, score_bcd, es);
    @(negedge CLOCK_50);
    chk({nm, " best@T+4"}, best_bcd, eb);
    chk({nm, " ready@T+4"}, {11'b0, clr_if.clr_ready}, 12'd1);
    if (timed) chk({nm, " HEX0@T+4"}, {5'b0, HEX0}, {5'b0, SEGS[int'(es[3:0])]});
  endtask

  task automatic bulk(input logic [2:0] lines, input int count);
    for (int k = 0; k < count; k++) begin
      exp_s = model_add(exp_s, lines);
      if (exp_s > exp_b) exp_b = exp_s;
      send(lines, 1'b0, exp_s, exp_b, "bulk");
    end
  endtask

  initial begin
    int acc;
    int t_acc [2];
    logic [11:0] s_mid;

    tbl[0] = '{3'd0, 12'h001, 12'h001};
    tbl[1] = '{3'd7, 12'h009, 12'h009};
    tbl[2] = '{3'd2, 12'h012, 12'h012};
    tbl[3] = '{3'd3, 12'h017, 12'h017};
    tbl[4] = '{3'd4, 12'h025, 12'h025};
    tbl[5] = '{3'd1, 12'h026, 12'h026};
    tbl[6] = '{3'd4, 12'h034, 12'h034};
    tbl[7] = '{3'd4, 12'h042, 12'h042};

    reset = 1'b1;
    new_game = 1'b0;
    clr_if.clr_valid = 1'b0;
    clr_if.clr_lines = 3'd0;
    repeat (2) @(negedge CLOCK_50);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge CLOCK_50);

    // First event: full timing and display lag
    send(3'd1, 1'b1, 12'h001, 12'h001, "first");
    @(negedge CLOCK_50);
    chk("first HEX3@T+5", {5'b0, HEX3}, 12'h079);
    chk("first HEX1", {5'b0, HEX1}, 12'h040);

    for (int i = 0; i < 8; i++) begin
      send(tbl[i].lines, 1'b1, tbl[i].score, tbl[i].best, $sformatf("vec%0d", i));
    end

    // new_game while in ADD1 discards the addition from 042
    clr_if.clr_valid = 1'b1;
    clr_if.clr_lines = 3'd4;
    @(negedge CLOCK_50);
    clr_if.clr_valid = 1'b0;
    @(negedge CLOCK_50);
    new_game = 1'b1;
    @(negedge CLOCK_50);
    new_game = 1'b0;
    chk("abort score", score_bcd, 12'h000);
    chk("abort ready", {11'b0, clr_if.clr_ready}, 12'd1);
    repeat (4) @(negedge CLOCK_50);
    chk("abort score later", score_bcd, 12'h000);
    chk("abort best", best_bcd, 12'h042);

    // new_game wins over a simultaneous event in IDLE
    new_game = 1'b1;
    clr_if.clr_valid = 1'b1;
    clr_if.clr_lines = 3'd4;
    @(negedge CLOCK_50);
    new_game = 1'b0;
    clr_if.clr_valid = 1'b0;
    chk("ng+valid ready", {11'b0, clr_if.clr_ready}, 12'd1);
    repeat (5) @(negedge CLOCK_50);
    chk("ng+valid score", score_bcd, 12'h000);

    // Valid held high: two lines=2 events accepted exactly 5 cycles apart
    clr_if.clr_valid = 1'b1;
    clr_if.clr_lines = 3'd2;
    acc = 0;
    s_mid = 12'hfff;
    t_acc[0] = 0;
    t_acc[1] = 0;
    for (int c = 0; c < 20 && acc < 2; c++) begin
      if (clr_if.clr_ready) begin
        t_acc[acc] = c;
        if (acc == 1) s_mid = score_bcd;
        acc++;
      end
      @(negedge CLOCK_50);
    end
    clr_if.clr_valid = 1'b0;
    chk("b2b accepts", 12'(acc), 12'd2);
    chk("b2b spacing", 12'(t_acc[1] - t_acc[0]), 12'd5);
    chk("b2b mid score", s_mid, 12'h003);
    repeat (4) @(negedge CLOCK_50);
    chk("b2b score", score_bcd, 12'h006);
    chk("b2b best", best_bcd, 12'h042);

    send(3'd0, 1'b1, 12'h006, 12'h042, "zero lines");

    // Build 000 -> 095, then cross two decimal carries to 103
    new_game = 1'b1;
    @(negedge CLOCK_50);
    new_game = 1'b0;
    exp_s = 12'h000;
    exp_b = 12'h042;
    bulk(3'd4, 11);
    bulk(3'd2, 2);
    bulk(3'd1, 1);
    chk("reach 095", score_bcd, 12'h095);
    send(3'd4, 1'b1, 12'h103, 12'h103, "carry 095");

    // 103 -> 996, then saturate
    exp_s = 12'h103;
    exp_b = 12'h103;
    bulk(3'd4, 111);
    bulk(3'd3, 1);
    chk("reach 996", score_bcd, 12'h996);
    send(3'd4, 1'b1, 12'h999, 12'h999, "saturate");
    send(3'd4, 1'b1, 12'h999, 12'h999, "stay 999");
    chk("HEX5 at 999", {5'b0, HEX5}, 12'h010);

    // Asynchronous reset in CMP while score 120 exceeds best 112
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    exp_s = 12'h000;
    exp_b = 12'h000;
    bulk(3'd4, 14);
    chk("reach 112", score_bcd, 12'h112);
    clr_if.clr_valid = 1'b1;
    clr_if.clr_lines = 3'd4;
    @(negedge CLOCK_50);
    clr_if.clr_valid = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    chk("pre-reset score", score_bcd, 12'h120);
    chk("pre-reset busy", {11'b0, busy}, 12'd1);
    #2 reset = 1'b1;
    #1 check_reset_values("async reset");
    @(negedge CLOCK_50);
    reset = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    chk("post-reset best", best_bcd, 12'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
